// File: rtl/vector_sweep_ctrl.sv
// Exhaustive input-sweep sequencer: drives 0..2^W-1, captures dut_out, emits records,
// accumulates a CRC-16 (0x1021) signature and ones count. Optional golden compare: SWEEP_COMPARE_EN.
module vector_sweep_ctrl #(
  parameter int unsigned W          = 5,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned SETTLE_W   = 4
) (
  input  logic            CK,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic [W-1:0]    N,
  input  logic            dut_out,
`ifdef SWEEP_COMPARE_EN
  input  logic            exp_bit,
  output logic [W:0]      mismatch_cnt,
  output logic [W-1:0]    first_fail_vec,
  output logic            fail_seen,
`endif
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [W-1:0]    rec_vec,
  output logic            rec_bit,
  output logic            busy,
  output logic            done,
  output logic [15:0]     signature,
  output logic [W:0]      ones_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SETTLE, S_CAPTURE, S_EMIT, S_DONE
  } state_t;

  localparam logic [W-1:0]        VEC_LAST    = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC);
  localparam logic [15:0]         SIG_SEED    = 16'hFFFF;
  localparam logic [15:0]         SIG_POLY    = 16'h1021;

  state_t              state_q, state_d;
  logic [W-1:0]        vec_q, vec_d;
  logic [W-1:0]        n_q, n_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]        rec_vec_q, rec_vec_d;
  logic                rec_bit_q, rec_bit_d;
  logic [15:0]         sig_q, sig_d;
  logic [W:0]          ones_q, ones_d;
  logic                fb;
`ifdef SWEEP_COMPARE_EN
  logic [W:0]          mm_q, mm_d;
  logic [W-1:0]        ffv_q, ffv_d;
  logic                fail_q, fail_d;
`endif

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      rec_vec_q <= '0;
      rec_bit_q <= 1'b0;
      sig_q     <= SIG_SEED;
      ones_q    <= '0;
`ifdef SWEEP_COMPARE_EN
      mm_q      <= '0;
      ffv_q     <= '0;
      fail_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      rec_vec_q <= rec_vec_d;
      rec_bit_q <= rec_bit_d;
      sig_q     <= sig_d;
      ones_q    <= ones_d;
`ifdef SWEEP_COMPARE_EN
      mm_q      <= mm_d;
      ffv_q     <= ffv_d;
      fail_q    <= fail_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    rec_vec_d = rec_vec_q;
    rec_bit_d = rec_bit_q;
    sig_d     = sig_q;
    ones_d    = ones_q;
    fb        = sig_q[15] ^ dut_out;
`ifdef SWEEP_COMPARE_EN
    mm_d      = mm_q;
    ffv_d     = ffv_q;
    fail_d    = fail_q;
`endif
    // abort outranks start and the handshake; accumulators are left frozen
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_DRIVE;
            vec_d   = '0;
            sig_d   = SIG_SEED;
            ones_d  = '0;
`ifdef SWEEP_COMPARE_EN
            mm_d    = '0;
            ffv_d   = '0;
            fail_d  = 1'b0;
`endif
          end
        end
        S_DRIVE: begin
          n_d     = vec_q;
          cnt_d   = SETTLE_LOAD;
          state_d = (SETTLE_CYC == 0) ? S_CAPTURE : S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q <= SETTLE_W'(1)) state_d = S_CAPTURE;
          else                       cnt_d   = cnt_q - SETTLE_W'(1);
        end
        S_CAPTURE: begin
          rec_bit_d = dut_out;
          rec_vec_d = vec_q;
          ones_d    = ones_q + (W+1)'(dut_out);
          sig_d     = {sig_q[14:0], 1'b0} ^ (fb ? SIG_POLY : 16'h0000);
`ifdef SWEEP_COMPARE_EN
          if (dut_out != exp_bit) begin
            mm_d = mm_q + (W+1)'(1);
            if (!fail_q) begin
              ffv_d  = vec_q;
              fail_d = 1'b1;
            end
          end
`endif
          state_d = S_EMIT;
        end
        S_EMIT: begin
          if (rec_ready) begin
            if (vec_q == VEC_LAST) begin
              state_d = S_DONE;
            end else begin
              vec_d   = vec_q + W'(1);
              state_d = S_DRIVE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign N          = n_q;
  assign rec_valid  = (state_q == S_EMIT);
  assign rec_vec    = rec_vec_q;
  assign rec_bit    = rec_bit_q;
  assign busy       = (state_q == S_DRIVE) || (state_q == S_SETTLE) ||
                      (state_q == S_CAPTURE) || (state_q == S_EMIT);
  assign done       = (state_q == S_DONE);
  assign signature  = sig_q;
  assign ones_count = ones_q;
`ifdef SWEEP_COMPARE_EN
  assign mismatch_cnt   = mm_q;
  assign first_fail_vec = ffv_q;
  assign fail_seen      = fail_q;
`endif

endmodule
